bcd_display_scan: RTL

//  Time-multiplexed 4-digit 7-segment scanner, downstream of the binary-to-BCD/7-seg decoder stage.
//  - Takes the four decoded digit patterns (unidad, decena, centena, miles).
//  - Drives one shared segment bus plus four active-low digit enables (anodes), one digit per refresh slot.
//  - Snapshots all four patterns once per frame so a digit never tears mid-scan.

---
 rtl/bcd_display_scan.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame snapshot of digit patterns.
// Optional dead-time at the start of each slot when DISPLAY_BLANKING_EN is defined.
module bcd_display_scan #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         REFRESH_HZ   = 1000,
  parameter int         BLANK_CYCLES = 16,
  parameter logic [6:0] SEG_OFF      = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] decoder_uni,
  input  logic [6:0] decoder_dec,
  input  logic [6:0] decoder_cent,
  input  logic [6:0] decoder_mil,
  output logic [6:0] seg_out,
  output logic [3:0] an_out,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int TICKS = CLK_FREQ / REFRESH_HZ;
  localparam int CW    = $clog2(TICKS);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic [6:0]      r_sh [4];

  state_t          w_state_nx;
  logic [CW-1:0]   w_cnt_nx;
  logic [1:0]      w_idx_nx;
  logic [6:0]      w_sh_nx [4];
  logic            w_wrap;
  logic            w_cap;
  logic            w_blank;
  logic            w_drive;
  logic [6:0]      w_seg_nx;
  logic [3:0]      w_an_nx;

  assign w_wrap = (r_cnt == CW'(TICKS - 1));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_cap      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        w_idx_nx = '0;
        if (en) begin
          w_state_nx = S_SCAN;
          w_cap      = 1'b1;
        end
      end
      S_SCAN: begin
        if (!en) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
        end else if (w_wrap) begin
          w_cnt_nx = '0;
          w_idx_nx = r_idx + 2'd1;
          w_cap    = (r_idx == 2'd3);
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_idx_nx   = '0;
      end
    endcase
  end

  always_comb begin
    w_sh_nx = r_sh;
    if (w_cap) begin
      w_sh_nx[0] = decoder_uni;
      w_sh_nx[1] = decoder_dec;
      w_sh_nx[2] = decoder_cent;
      w_sh_nx[3] = decoder_mil;
    end
  end

`ifdef DISPLAY_BLANKING_EN
  assign w_blank = (w_cnt_nx < CW'(BLANK_CYCLES));
`else
  assign w_blank = 1'b0;
`endif

  // Outputs are registered from next-state so they line up with the slot.
  always_comb begin
    w_drive  = (w_state_nx == S_SCAN) && !w_blank;
    w_seg_nx = SEG_OFF;
    w_an_nx  = 4'b1111;
    if (w_drive) begin
      w_seg_nx = w_sh_nx[w_idx_nx];
      w_an_nx  = ~(4'b0001 << w_idx_nx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sh[0]    <= SEG_OFF;
      r_sh[1]    <= SEG_OFF;
      r_sh[2]    <= SEG_OFF;
      r_sh[3]    <= SEG_OFF;
      seg_out    <= SEG_OFF;
      an_out     <= 4'b1111;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_idx      <= w_idx_nx;
      r_sh       <= w_sh_nx;
      seg_out    <= w_seg_nx;
      an_out     <= w_an_nx;
      digit_idx  <= w_idx_nx;
      frame_tick <= w_cap;
    end
  end

endmodule
